// File: rtl/div_sched.sv
`default_nettype none
// ============================================================================
// Module   : div_sched
// Purpose  : Round-robin front end that shares one iterative unsigned divider
//            among NREQ requesters. Grants one request at a time, converts
//            signed operands to magnitudes, runs the divider start/done
//            handshake, answers divide-by-zero locally, sign-corrects the
//            result and aborts a hung divider via a watchdog.
// Ports    : clk, rst_n            clock, asynchronous active-low reset
//            req_valid/req_ready   per-requester request / one-hot accept pulse
//            req_signed            per-requester signed-division flag
//            req_dividend/divisor  packed operands, requester i at [i*WIDTH +: WIDTH]
//            resp_valid/id         one-cycle result pulse and owner index
//            resp_quotient/rem     final results (held while resp_valid = 0)
//            resp_err              0 ok, 1 divide-by-zero, 2 timeout
//            div_start/dividend/divisor   request side of the shared divider
//            div_quotient/remainder/done  completion side of the shared divider
// Revision : 1.0  initial release
// ============================================================================
module div_sched #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_signed,
  input  logic [NREQ*WIDTH-1:0]    req_dividend,
  input  logic [NREQ*WIDTH-1:0]    req_divisor,
  output logic                     resp_valid,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [WIDTH-1:0]         resp_quotient,
  output logic [WIDTH-1:0]         resp_remainder,
  output logic [1:0]               resp_err,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder,
  input  logic                     div_done
);

  localparam int IDW = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ZCHK = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_DIV0 = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  logic [2:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;      // original operands as presented
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;      // raw divider results
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_quo_q, resp_quo_d;
  logic [WIDTH-1:0] resp_rem_q, resp_rem_d;
  logic [1:0]       resp_err_q, resp_err_d;

  logic             grant_any;
  logic [IDW-1:0]   grant_idx;
  logic             dvd_neg, dvs_neg, dvs_zero, wdog_expired;
  logic [WIDTH-1:0] mag_dvd, mag_dvs;

  // Round-robin search: first asserted request strictly after the last winner.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_any && req_valid[(int'(ptr_q) + k) % NREQ]) begin
        grant_any = 1'b1;
        grant_idx = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign dvd_neg  = sgn_q & dvd_q[WIDTH-1];
  assign dvs_neg  = sgn_q & dvs_q[WIDTH-1];
  assign mag_dvd  = dvd_neg ? (~dvd_q + 1'b1) : dvd_q;
  assign mag_dvs  = dvs_neg ? (~dvs_q + 1'b1) : dvs_q;
  assign dvs_zero = (dvs_q == '0);
  // wdog_q is 0 in the first WAIT cycle, so this fires on the last WAIT cycle
  // and RESP lands exactly TIMEOUT cycles after div_start.
  assign wdog_expired = (wdog_q == WDW'(TIMEOUT - 2));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= IDW'(NREQ - 1);
      id_q       <= '0;
      sgn_q      <= 1'b0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      wdog_q     <= '0;
      resp_id_q  <= '0;
      resp_quo_q <= '0;
      resp_rem_q <= '0;
      resp_err_q <= ERR_OK;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      sgn_q      <= sgn_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      wdog_q     <= wdog_d;
      resp_id_q  <= resp_id_d;
      resp_quo_q <= resp_quo_d;
      resp_rem_q <= resp_rem_d;
      resp_err_q <= resp_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (grant_any) state_d = S_ZCHK;
      S_ZCHK: state_d = dvs_zero ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (div_done)          state_d = S_FIX;
        else if (wdog_expired) state_d = S_RESP;
      end
      S_FIX:   state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    ptr_d      = ptr_q;
    id_d       = id_q;
    sgn_d      = sgn_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    wdog_d     = wdog_q;
    resp_id_d  = resp_id_q;
    resp_quo_d = resp_quo_q;
    resp_rem_d = resp_rem_q;
    resp_err_d = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          ptr_d = grant_idx;
          id_d  = grant_idx;
          sgn_d = req_signed[grant_idx];
          dvd_d = req_dividend[int'(grant_idx)*WIDTH +: WIDTH];
          dvs_d = req_divisor[int'(grant_idx)*WIDTH +: WIDTH];
        end
      end
      S_ZCHK: begin
        if (dvs_zero) begin
          resp_id_d  = id_q;
          resp_quo_d = '1;
          resp_rem_d = dvd_q;
          resp_err_d = ERR_DIV0;
        end else begin
          wdog_d = '0;
        end
      end
      S_WAIT: begin
        wdog_d = wdog_q + WDW'(1);
        if (div_done) begin
          quo_d = div_quotient;
          rem_d = div_remainder;
        end else if (wdog_expired) begin
          resp_id_d  = id_q;
          resp_quo_d = '0;
          resp_rem_d = '0;
          resp_err_d = ERR_TMO;
        end
      end
      S_FIX: begin
        // Most-negative / -1 wraps back to most-negative on its own.
        resp_id_d  = id_q;
        resp_quo_d = (dvd_neg ^ dvs_neg) ? (~quo_q + 1'b1) : quo_q;
        resp_rem_d = dvd_neg ? (~rem_q + 1'b1) : rem_q;
        resp_err_d = ERR_OK;
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready    = '0;
    div_start    = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;
    resp_valid   = 1'b0;
    // Gated by rst_n so no acceptance is signalled while held in reset.
    if (state_q == S_IDLE && grant_any && rst_n) req_ready[grant_idx] = 1'b1;
    if ((state_q == S_ZCHK && !dvs_zero) || state_q == S_WAIT) begin
      div_dividend = mag_dvd;
      div_divisor  = mag_dvs;
    end
    if (state_q == S_ZCHK && !dvs_zero) div_start = 1'b1;
    if (state_q == S_RESP) resp_valid = 1'b1;
  end

  assign resp_id        = resp_id_q;
  assign resp_quotient  = resp_quo_q;
  assign resp_remainder = resp_rem_q;
  assign resp_err       = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_sched
// Purpose  : Directed self-checking bench for div_sched with a behavioural
//            3-cycle divider stub that can be told to hang.
// Revision : 1.0  initial release
// ============================================================================
module tb_div_sched;

  localparam int WIDTH   = 32;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid, req_ready, req_signed;
  logic [NREQ*WIDTH-1:0]   req_dividend, req_divisor;
  logic                    resp_valid;
  logic [1:0]              resp_id;
  logic [WIDTH-1:0]        resp_quotient, resp_remainder;
  logic [1:0]              resp_err;
  logic                    div_start, div_done;
  logic [WIDTH-1:0]        div_dividend, div_divisor, div_quotient, div_remainder;

  div_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_quotient(resp_quotient),
    .resp_remainder(resp_remainder), .resp_err(resp_err),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle counter and event monitor
  int cyc = 0;
  int n_start = 0, n_resp = 0, g_cnt = 0;
  int start_cyc = 0, done_cyc = 0, acc_cyc = 0;
  int grant_id_a[64];
  int grant_cyc_a[64];
  logic [WIDTH-1:0] mon_dd = '0, mon_dv = '0;

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (req_ready != '0) begin
      if (g_cnt < 64) begin
        grant_id_a[g_cnt]  <= onehot_idx(req_ready);
        grant_cyc_a[g_cnt] <= cyc;
      end
      g_cnt   <= g_cnt + 1;
      acc_cyc <= cyc;
    end
    if (div_start) begin
      n_start   <= n_start + 1;
      start_cyc <= cyc;
      mon_dd    <= div_dividend;
      mon_dv    <= div_divisor;
    end
    if (div_done)   done_cyc <= cyc;
    if (resp_valid) n_resp   <= n_resp + 1;
  end

  // Divider stub: answers 3 cycles after div_start unless hang is set.
  bit hang = 1'b0;
  initial begin
    bit pend = 1'b0;
    int lat  = 0;
    div_done = 1'b0; div_quotient = '0; div_remainder = '0;
    forever begin
      @(posedge clk); #1;
      div_done = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          lat--;
          if (lat == 0) begin div_done = 1'b1; pend = 1'b0; end
        end
        if (div_start && !hang) begin
          pend = 1'b1; lat = 3;
          div_quotient  = div_dividend / div_divisor;
          div_remainder = div_dividend % div_divisor;
        end
      end
    end
  end

  // Captured response
  logic [1:0]       got_id;
  logic [WIDTH-1:0] got_q, got_r;
  logic [1:0]       got_err;
  int               got_cyc;

  task automatic accept_drop(input int id);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (req_ready[id]) seen = 1'b1;
    end
    check($sformatf("accept_%0d", id), 64'(seen), 64'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic issue(input int id, input bit sg, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    req_dividend[id*WIDTH +: WIDTH] = a;
    req_divisor[id*WIDTH +: WIDTH]  = b;
    req_signed[id] = sg;
    req_valid[id]  = 1'b1;
    accept_drop(id);
  endtask

  task automatic wait_resp();
    bit seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        got_id = resp_id; got_q = resp_quotient; got_r = resp_remainder;
        got_err = resp_err; got_cyc = cyc;
      end
    end
    check("resp_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, gbase, prev_cyc, rc;
    int exp_id[6] = '{0, 2, 3, 0, 2, 3};
    logic [31:0] exp_q[4] = '{32'd10, 32'd0, 32'd9, 32'd333};
    logic [31:0] exp_r[4] = '{32'd0, 32'd0, 32'd0, 32'd1};

    rst_n = 1'b1; req_valid = '0; req_signed = '0; req_dividend = '0; req_divisor = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready",  64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_div_start",  64'(div_start), 64'd0);
    check("rst_resp_q",     64'(resp_quotient), 64'd0);
    check("rst_resp_err",   64'(resp_err), 64'd0);
    check("rst_div_dvd",    64'(div_dividend), 64'd0);
    rst_n = 1'b1;

    // Unsigned 100/7
    s0 = n_start;
    issue(0, 1'b0, 32'd100, 32'd7);
    wait_resp();
    check("u_id",  64'(got_id), 64'd0);
    check("u_q",   64'(got_q), 64'd14);
    check("u_r",   64'(got_r), 64'd2);
    check("u_err", 64'(got_err), 64'd0);
    check("u_starts", 64'(n_start - s0), 64'd1);
    check("u_lat",    64'(got_cyc - done_cyc), 64'd2);
    check("u_div_dd", 64'(mon_dd), 64'd100);

    // Signed -100/7
    issue(1, 1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_resp();
    check("s1_div_dd", 64'(mon_dd), 64'd100);
    check("s1_div_dv", 64'(mon_dv), 64'd7);
    check("s1_id", 64'(got_id), 64'd1);
    check("s1_q",  64'(got_q), 64'hFFFF_FFF2);
    check("s1_r",  64'(got_r), 64'hFFFF_FFFE);

    // Signed 100/-7
    issue(2, 1'b1, 32'd100, 32'hFFFF_FFF9);
    wait_resp();
    check("s2_div_dv", 64'(mon_dv), 64'd7);
    check("s2_q", 64'(got_q), 64'hFFFF_FFF2);
    check("s2_r", 64'(got_r), 64'd2);

    // Divide-by-zero
    s0 = n_start;
    issue(3, 1'b0, 32'h1234, 32'd0);
    wait_resp();
    check("z_starts", 64'(n_start - s0), 64'd0);
    check("z_lat",  64'(got_cyc - acc_cyc), 64'd2);
    check("z_id",   64'(got_id), 64'd3);
    check("z_q",    64'(got_q), 64'hFFFF_FFFF);
    check("z_r",    64'(got_r), 64'h1234);
    check("z_err",  64'(got_err), 64'd1);

    // Arbitration: 0, 2, 3 held valid for six operations
    @(posedge clk); #1;
    req_signed = '0;
    req_dividend[0*WIDTH +: WIDTH] = 32'd50;   req_divisor[0*WIDTH +: WIDTH] = 32'd5;
    req_dividend[2*WIDTH +: WIDTH] = 32'd81;   req_divisor[2*WIDTH +: WIDTH] = 32'd9;
    req_dividend[3*WIDTH +: WIDTH] = 32'd1000; req_divisor[3*WIDTH +: WIDTH] = 32'd3;
    gbase = g_cnt;
    req_valid = 4'b1101;
    prev_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      wait_resp();
      if (i == 5) req_valid = '0;
      check($sformatf("arb_id_%0d", i), 64'(got_id), 64'(exp_id[i]));
      check($sformatf("arb_q_%0d", i),  64'(got_q), 64'(exp_q[exp_id[i]]));
      check($sformatf("arb_r_%0d", i),  64'(got_r), 64'(exp_r[exp_id[i]]));
      check($sformatf("arb_grant_%0d", i), 64'(grant_id_a[gbase+i]), 64'(exp_id[i]));
      check($sformatf("arb_outstanding_%0d", i), 64'(g_cnt - gbase), 64'(i + 1));
      if (i > 0)
        check($sformatf("arb_regrant_%0d", i), 64'(grant_cyc_a[gbase+i] - prev_cyc), 64'd1);
      prev_cyc = got_cyc;
    end

    // Timeout with a hung divider, then normal recovery
    hang = 1'b1;
    issue(1, 1'b0, 32'd10, 32'd2);
    wait_resp();
    check("t_lat", 64'(got_cyc - start_cyc), 64'(TIMEOUT));
    check("t_id",  64'(got_id), 64'd1);
    check("t_err", 64'(got_err), 64'd2);
    check("t_q",   64'(got_q), 64'd0);
    check("t_r",   64'(got_r), 64'd0);
    hang = 1'b0;
    issue(2, 1'b0, 32'd9, 32'd3);
    wait_resp();
    check("rec_q",   64'(got_q), 64'd3);
    check("rec_err", 64'(got_err), 64'd0);

    // Reset in the middle of WAIT
    hang = 1'b1;
    issue(0, 1'b0, 32'd7, 32'd1);
    repeat (3) @(negedge clk);
    check("w_dd_stable", 64'(div_dividend), 64'd7);
    rst_n = 1'b0;
    #1;
    check("mr_resp_valid", 64'(resp_valid), 64'd0);
    check("mr_div_dvd",    64'(div_dividend), 64'd0);
    check("mr_resp_q",     64'(resp_quotient), 64'd0);
    check("mr_resp_id",    64'(resp_id), 64'd0);
    check("mr_req_ready",  64'(req_ready), 64'd0);
    rc = n_resp;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hang  = 1'b0;
    repeat (6) @(negedge clk);
    check("mr_no_resp", 64'(n_resp), 64'(rc));

    // After reset requester 0 wins first; then signed overflow on 3
    @(posedge clk); #1;
    req_signed = 4'b1000;
    req_dividend[0*WIDTH +: WIDTH] = 32'd5;          req_divisor[0*WIDTH +: WIDTH] = 32'd1;
    req_dividend[3*WIDTH +: WIDTH] = 32'h8000_0000;  req_divisor[3*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
    req_valid = 4'b1001;
    accept_drop(0);
    wait_resp();
    check("pr_id", 64'(got_id), 64'd0);
    check("pr_q",  64'(got_q), 64'd5);
    accept_drop(3);
    wait_resp();
    check("ov_id",  64'(got_id), 64'd3);
    check("ov_q",   64'(got_q), 64'h8000_0000);
    check("ov_r",   64'(got_r), 64'd0);
    check("ov_err", 64'(got_err), 64'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_sched.md
Name: div_sched

Overview:
- Round-robin scheduler that shares one iterative unsigned divider among NREQ requesters (e.g. EX-stage DIV path, debug unit, microcode sequencer).
- Arbitrates requests and converts signed operands to magnitudes.
- Sequences the divider's start/done handshake and handles divide-by-zero locally without invoking the divider.
- Returns sign-corrected results on a shared response bus tagged with the requester index. Includes a watchdog against a hung divider.

Parameters:
- WIDTH, 32: operand and result width.
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT, 64: max cycles from div_start to div_done before abort; must exceed WIDTH+4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request; held until accepted
- req_ready  out  NREQ  one-hot acceptance pulse, one cycle
- req_signed  in  NREQ  1 = signed division for that requester
- req_dividend  in  NREQ*WIDTH  packed dividends; requester i at bits [i*WIDTH +: WIDTH]
- req_divisor  in  NREQ*WIDTH  packed divisors, same packing
- resp_valid  out  1  result valid, one-cycle pulse, no backpressure
- resp_id  out  $clog2(NREQ)  index of requester owning the response
- resp_quotient  out  WIDTH  final quotient
- resp_remainder  out  WIDTH  final remainder
- resp_err  out  2  0 = ok, 1 = divide-by-zero, 2 = timeout
- div_start  out  1  one-cycle start pulse to divider
- div_dividend  out  WIDTH  unsigned dividend magnitude to divider
- div_divisor  out  WIDTH  unsigned divisor magnitude to divider
- div_quotient  in  WIDTH  divider quotient
- div_remainder  in  WIDTH  divider remainder
- div_done  in  1  divider completion pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = NREQ-1, so requester 0 has first priority.
- State IDLE:
  - If any req_valid is set, grant the first asserted index searching upward (with wrap) from pointer+1.
  - Pulse req_ready[g] and latch operands, signed flag and id.
  - Set pointer = g.
  - Go to ZCHK.
  - Requests arriving in other states wait; req_ready stays 0 outside IDLE.
- State ZCHK (1 cycle):
  - If divisor == 0: go to RESP with quotient = all ones, remainder = original dividend, err = 1.
  - Otherwise: drive div_dividend/div_divisor with magnitudes, pulse div_start, clear the watchdog, go to WAIT.
  - Magnitude: two's-complement negate if signed and MSB set; otherwise pass unchanged.
- State WAIT:
  - Watchdog increments each cycle.
  - div_dividend/div_divisor stay stable throughout WAIT.
  - On div_done, capture div_quotient/div_remainder and go to FIX.
  - If the watchdog reaches TIMEOUT without div_done: go to RESP with quotient = 0, remainder = 0, err = 2.
  - div_done outside WAIT is ignored.
- State FIX (1 cycle), signed only:
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder is negated if the dividend was negative.
  - Unsigned requests pass through unchanged.
  - Overflow case (most-negative / -1) yields quotient = most-negative, remainder = 0, err = 0. This is the natural wrap; no special-casing.
- State RESP (1 cycle): assert resp_valid with resp_id, quotient, remainder and err; go to IDLE.
  - resp_* data buses hold their last value when resp_valid = 0.
- Latency:
  - Divide-by-zero: resp_valid 2 cycles after req_ready.
  - Normal: resp_valid 2 cycles after div_done.
  - Next grant is possible the cycle after resp_valid.
- Simultaneous requests: exactly one grant per IDLE visit. Fairness: with all requesters asserting continuously, the grant order is 0, 1, 2, …, NREQ-1, 0, …
- A requester dropping req_valid before acceptance is legal; its request is simply not granted.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The in-flight result is discarded and no resp_valid is issued. The divider shares rst_n.

Test Plan:
- Unsigned: req 0 with 100/7 -> req_ready[0] pulse; div_start once; resp_id = 0, quotient = 14, remainder = 2, err = 0.
- Signed: req 1 with -100/7 (signed) -> divider sees 100/7; response quotient = -14 (0xFFFFFFF2), remainder = -2 (0xFFFFFFFE). Also 100/-7 -> quotient = -14, remainder = 2.
- Divide-by-zero: 0x1234/0 -> no div_start; resp 2 cycles after accept with quotient = 0xFFFFFFFF, remainder = 0x1234, err = 1.
- Arbitration: requesters 0, 2, 3 valid continuously for 6 operations -> grant order 0, 2, 3, 0, 2, 3; resp_id matches each grant; exactly one outstanding at a time.
- Timeout: stub divider never asserts div_done -> resp exactly TIMEOUT cycles after div_start with err = 2, quotient = 0, remainder = 0; next request then accepted normally.
- Reset mid-WAIT: assert rst_n low during WAIT -> all outputs 0 immediately, no resp_valid; after release, 0x80000000 / -1 signed -> quotient = 0x80000000, remainder = 0, err = 0.
